// File: rtl/point_scalar_mult_pkg.sv
// Shared types and GF(3^97) arithmetic for the scalar multiplier and its point adder.
// Field elements are held as hi/lo bit planes; the external 2-bit-per-digit encoding is 00=0, 01=1, 10=2.
package point_scalar_mult_pkg;

  localparam int WIDTH    = 193;
  localparam int COORD_W  = WIDTH + 1;
  localparam int M        = 97;
  localparam int POLY_MID = 12;

  typedef struct packed {
    logic [M-1:0] hi;
    logic [M-1:0] lo;
  } f3_t;

  localparam f3_t F3_ONE = '{hi: '0, lo: {{(M-1){1'b0}}, 1'b1}};

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_OP_RST  = 4'b0010,
    S_OP_WAIT = 4'b0100,
    S_FIN     = 4'b1000
  } psm_state_e;

  typedef enum logic {
    MODE_DBL = 1'b0,
    MODE_ADD = 1'b1
  } op_mode_e;

  typedef enum logic [1:0] {
    PA_CHECK = 2'd0,
    PA_INV   = 2'd1,
    PA_OUT   = 2'd2,
    PA_DONE  = 2'd3
  } pa_state_e;

  function automatic f3_t f3_unpack(input logic [COORD_W-1:0] e);
    f3_t r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      r.lo[i] = e[2*i];
      r.hi[i] = e[2*i+1];
    end
    return r;
  endfunction

  function automatic logic [COORD_W-1:0] f3_pack(input f3_t a);
    logic [COORD_W-1:0] e;
    e = '0;
    for (int i = 0; i < M; i++) begin
      e[2*i]   = a.lo[i];
      e[2*i+1] = a.hi[i];
    end
    return e;
  endfunction

  function automatic f3_t f3_add(input f3_t a, input f3_t b);
    f3_t r;
    logic [M-1:0] t;
    t    = (a.hi | b.lo) ^ (a.lo | b.hi);
    r.hi = (a.lo | b.lo) ^ t;
    r.lo = (a.hi | b.hi) ^ t;
    return r;
  endfunction

  function automatic f3_t f3_neg(input f3_t a);
    f3_t r;
    r.hi = a.lo;
    r.lo = a.hi;
    return r;
  endfunction

  function automatic f3_t f3_sub(input f3_t a, input f3_t b);
    return f3_add(a, f3_neg(b));
  endfunction

  // Multiply every coefficient of a by one GF(3) digit (d_hi, d_lo).
  function automatic f3_t f3_scale(input f3_t a, input logic d_hi, input logic d_lo);
    f3_t r;
    r.hi = ({M{d_lo}} & a.hi) | ({M{d_hi}} & a.lo);
    r.lo = ({M{d_lo}} & a.lo) | ({M{d_hi}} & a.hi);
    return r;
  endfunction

  // a*x mod (x^97 + x^12 + 2), using x^97 = 2x^12 + 1.
  function automatic f3_t f3_mulx(input f3_t a);
    f3_t r;
    f3_t t;
    r.hi = {a.hi[M-2:0], a.hi[M-1]};
    r.lo = {a.lo[M-2:0], a.lo[M-1]};
    t = '0;
    t.hi[POLY_MID] = a.lo[M-1];
    t.lo[POLY_MID] = a.hi[M-1];
    return f3_add(r, t);
  endfunction

  function automatic f3_t f3_mul(input f3_t a, input f3_t b);
    f3_t acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = f3_mulx(acc);
      acc = f3_add(acc, f3_scale(a, b.hi[i], b.lo[i]));
    end
    return acc;
  endfunction

  function automatic f3_t f3_cube(input f3_t a);
    return f3_mul(f3_mul(a, a), a);
  endfunction

endpackage

// File: rtl/point_scalar_mult_point_add.sv
// Affine point addition/doubling on y^2 = x^3 - x + 1 over GF(3^97).
// Starts when reset_i is released; result and done_o hold until the next reset_i.
module point_add
  import point_scalar_mult_pkg::*;
(
  input  logic           clk,
  input  logic           reset_i,
  input  logic [WIDTH:0] x1_i,
  input  logic [WIDTH:0] y1_i,
  input  logic           zero1_i,
  input  logic [WIDTH:0] x2_i,
  input  logic [WIDTH:0] y2_i,
  input  logic           zero2_i,
  output logic           done_o,
  output logic [WIDTH:0] x3_o,
  output logic [WIDTH:0] y3_o,
  output logic           zero3_o
);

  localparam int CNT_W = $clog2(M);

  pa_state_e      state_q, state_d;
  f3_t            num_q, num_d, den_q, den_d, d2_q, d2_d, inv_q, inv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           dbl_q, dbl_d;
  logic [WIDTH:0] x3_q, x3_d, y3_q, y3_d;
  logic           zero3_q, zero3_d, done_q, done_d;
  f3_t            fx1, fy1, fx2, fy2;
  f3_t            den_v, lam, lam2, lam3;

  assign fx1 = f3_unpack(x1_i);
  assign fy1 = f3_unpack(y1_i);
  assign fx2 = f3_unpack(x2_i);
  assign fy2 = f3_unpack(y2_i);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= PA_CHECK;
      num_q   <= '0;
      den_q   <= '0;
      d2_q    <= '0;
      inv_q   <= '0;
      cnt_q   <= '0;
      dbl_q   <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
      zero3_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      d2_q    <= d2_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      dbl_q   <= dbl_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      zero3_q <= zero3_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    d2_d    = d2_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    dbl_d   = dbl_q;
    x3_d    = x3_q;
    y3_d    = y3_q;
    zero3_d = zero3_q;
    done_d  = done_q;
    den_v   = '0;
    lam     = '0;
    lam2    = '0;
    lam3    = '0;
    case (state_q)
      PA_CHECK: begin
        if (zero1_i) begin
          x3_d    = zero2_i ? '0 : x2_i;
          y3_d    = zero2_i ? '0 : y2_i;
          zero3_d = zero2_i;
          done_d  = 1'b1;
          state_d = PA_DONE;
        end else if (zero2_i) begin
          x3_d    = x1_i;
          y3_d    = y1_i;
          zero3_d = 1'b0;
          done_d  = 1'b1;
          state_d = PA_DONE;
        end else if (x1_i == x2_i && (y1_i != y2_i || y1_i == '0)) begin
          // P + (-P), or doubling a point of order 2
          x3_d    = '0;
          y3_d    = '0;
          zero3_d = 1'b1;
          done_d  = 1'b1;
          state_d = PA_DONE;
        end else begin
          // Doubling slope is 1/y since -1/(2y) = 1/y in characteristic 3
          dbl_d   = (x1_i == x2_i);
          num_d   = dbl_d ? F3_ONE : f3_sub(fy2, fy1);
          den_v   = dbl_d ? fy1 : f3_sub(fx2, fx1);
          den_d   = den_v;
          d2_d    = f3_mul(den_v, den_v);
          inv_d   = F3_ONE;
          cnt_d   = CNT_W'(M - 1);
          state_d = PA_INV;
        end
      end
      PA_INV: begin
        // Base-3 exponentiation to 3^97-2 = (22...21)_3: digit 2 until the last step
        inv_d = f3_mul(f3_cube(inv_q), (cnt_q == '0) ? den_q : d2_q);
        if (cnt_q == '0) begin
          state_d = PA_OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PA_OUT: begin
        lam  = f3_mul(num_q, inv_q);
        lam2 = f3_mul(lam, lam);
        lam3 = f3_mul(lam2, lam);
        if (dbl_q) begin
          x3_d = f3_pack(f3_add(fx1, lam2));
          y3_d = f3_pack(f3_neg(f3_add(fy1, lam3)));
        end else begin
          x3_d = f3_pack(f3_sub(f3_sub(lam2, fx1), fx2));
          y3_d = f3_pack(f3_sub(f3_add(fy1, fy2), lam3));
        end
        zero3_d = 1'b0;
        done_d  = 1'b1;
        state_d = PA_DONE;
      end
      PA_DONE: begin
      end
      default: state_d = PA_CHECK;
    endcase
  end

  assign done_o  = done_q;
  assign x3_o    = x3_q;
  assign y3_o    = y3_q;
  assign zero3_o = zero3_q;

endmodule

// File: rtl/point_scalar_mult.sv
// Q = k*P by left-to-right double-and-add, sequencing one point_add responder per step.
//   state     | meaning
//   S_IDLE    | waiting for start; result and done held
//   S_OP_RST  | operands presented, point_add held in reset for one cycle
//   S_OP_WAIT | waiting for point_add done, then R := result and pick next op
//   S_FIN     | publish R on x3/y3/zero3, raise done, drop busy
module point_scalar_mult
  import point_scalar_mult_pkg::*;
#(
  parameter int SCALAR_W = 152
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SCALAR_W-1:0] k,
  input  logic [WIDTH:0]      x1,
  input  logic [WIDTH:0]      y1,
  input  logic                zero1,
  output logic                busy,
  output logic                done,
  output logic [WIDTH:0]      x3,
  output logic [WIDTH:0]      y3,
  output logic                zero3
);

  localparam int IDX_W = $clog2(SCALAR_W);

  psm_state_e          state_q, state_d;
  op_mode_e            mode_q, mode_d;
  logic [SCALAR_W-1:0] k_q, k_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WIDTH:0]      px_q, px_d, py_q, py_d, rx_q, rx_d, ry_q, ry_d;
  logic                pz_q, pz_d, rz_q, rz_d;
  logic [WIDTH:0]      x3_q, x3_d, y3_q, y3_d;
  logic                zero3_q, zero3_d, busy_q, busy_d, done_q, done_d;

  logic                pa_reset, pa_done, pa_zero2, pa_zero3;
  logic [WIDTH:0]      pa_x2, pa_y2, pa_x3, pa_y3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_DBL;
      k_q     <= '0;
      idx_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pz_q    <= 1'b0;
      rx_q    <= '0;
      ry_q    <= '0;
      rz_q    <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
      zero3_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pz_q    <= pz_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rz_q    <= rz_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      zero3_q <= zero3_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    pz_d    = pz_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rz_d    = rz_q;
    x3_d    = x3_q;
    y3_d    = y3_q;
    zero3_d = zero3_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = k;
          px_d    = x1;
          py_d    = y1;
          pz_d    = zero1;
          rx_d    = '0;
          ry_d    = '0;
          rz_d    = 1'b1;
          idx_d   = IDX_W'(SCALAR_W - 1);
          mode_d  = MODE_DBL;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_OP_RST;
        end
      end
      S_OP_RST: state_d = S_OP_WAIT;
      S_OP_WAIT: begin
        if (pa_done) begin
          rx_d = pa_x3;
          ry_d = pa_y3;
          rz_d = pa_zero3;
          if (mode_q == MODE_DBL && k_q[idx_q]) begin
            mode_d  = MODE_ADD;
            state_d = S_OP_RST;
          end else if (idx_q == '0) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            mode_d  = MODE_DBL;
            state_d = S_OP_RST;
          end
        end
      end
      S_FIN: begin
        x3_d    = rz_q ? '0 : rx_q;
        y3_d    = rz_q ? '0 : ry_q;
        zero3_d = rz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands stay put through S_OP_RST and S_OP_WAIT because R only changes on pa_done.
  assign pa_reset = ~reset | (state_q == S_OP_RST);
  assign pa_x2    = (mode_q == MODE_ADD) ? px_q : rx_q;
  assign pa_y2    = (mode_q == MODE_ADD) ? py_q : ry_q;
  assign pa_zero2 = (mode_q == MODE_ADD) ? pz_q : rz_q;

  point_add u_point_add (
    .clk     (clk),
    .reset_i (pa_reset),
    .x1_i    (rx_q),
    .y1_i    (ry_q),
    .zero1_i (rz_q),
    .x2_i    (pa_x2),
    .y2_i    (pa_y2),
    .zero2_i (pa_zero2),
    .done_o  (pa_done),
    .x3_o    (pa_x3),
    .y3_o    (pa_y3),
    .zero3_o (pa_zero3)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign x3    = x3_q;
  assign y3    = y3_q;
  assign zero3 = zero3_q;

endmodule

// File: tb/tb_point_scalar_mult.sv
// Directed bench for point_scalar_mult using multiples of P=(0,1), a point of order 7.
module tb_point_scalar_mult;
  import point_scalar_mult_pkg::*;

  localparam int SW     = 152;
  localparam int BUDGET = 40000;
  localparam logic [WIDTH:0] F0 = '0;
  localparam logic [WIDTH:0] F1 = COORD_W'(1);
  localparam logic [WIDTH:0] F2 = COORD_W'(2);

  logic           clk = 1'b0;
  logic           reset, start, zero1;
  logic [SW-1:0]  k;
  logic [WIDTH:0] x1, y1;
  logic           busy, done, zero3;
  logic [WIDTH:0] x3, y3;
  int             n_checks = 0;
  int             n_fails  = 0;
  logic           busy_prev;

  point_scalar_mult #(.SCALAR_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .k     (k),
    .x1    (x1),
    .y1    (y1),
    .zero1 (zero1),
    .busy  (busy),
    .done  (done),
    .x3    (x3),
    .y3    (y3),
    .zero3 (zero3)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_fe(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [SW-1:0] kv, input logic zv);
    @(negedge clk);
    k     = kv;
    x1    = F0;
    y1    = F1;
    zero1 = zv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic bprev);
    int n;
    n     = 0;
    bprev = busy;
    while (done !== 1'b1 && n < BUDGET) begin
      bprev = busy;
      @(negedge clk);
      n++;
    end
    check_bit({tag, ".done"}, done, 1'b1);
  endtask

  task automatic expect_pt(input string tag, input logic [WIDTH:0] ex, input logic [WIDTH:0] ey,
                           input logic ez);
    check_fe({tag, ".x3"}, x3, ex);
    check_fe({tag, ".y3"}, y3, ey);
    check_bit({tag, ".zero3"}, zero3, ez);
  endtask

  task automatic run(input string tag, input logic [SW-1:0] kv, input logic zv,
                     input logic [WIDTH:0] ex, input logic [WIDTH:0] ey, input logic ez);
    logic bp;
    start_op(kv, zv);
    check_bit({tag, ".busy_on_start"}, busy, 1'b1);
    check_bit({tag, ".done_cleared"}, done, 1'b0);
    wait_done(tag, bp);
    expect_pt(tag, ex, ey, ez);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    k     = '0;
    x1    = '0;
    y1    = '0;
    zero1 = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rst.busy", busy, 1'b0);
    check_bit("rst.done", done, 1'b0);
    expect_pt("rst", F0, F0, 1'b0);
    reset = 1'b1;

    run("k0", SW'(0), 1'b0, F0, F0, 1'b1);
    repeat (3) @(negedge clk);
    check_bit("k0.done_held", done, 1'b1);
    run("k1", SW'(1), 1'b0, F0, F1, 1'b0);
    run("k2", SW'(2), 1'b0, F1, F1, 1'b0);
    run("k3", SW'(3), 1'b0, F2, F2, 1'b0);
    run("k7", SW'(7), 1'b0, F0, F0, 1'b1);
    run("k8", SW'(8), 1'b0, F0, F1, 1'b0);
    run("kones", {SW{1'b1}}, 1'b0, F2, F2, 1'b0);

    // P at infinity; busy must fall on the very cycle done rises
    start_op(SW'(5), 1'b1);
    wait_done("inf", busy_prev);
    check_bit("inf.busy_before_done", busy_prev, 1'b1);
    check_bit("inf.busy_at_done", busy, 1'b0);
    expect_pt("inf", F0, F0, 1'b1);

    // Abort by reset mid-run, then a clean run
    start_op(SW'(3), 1'b0);
    repeat (40) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_bit("abort.busy", busy, 1'b0);
    check_bit("abort.done", done, 1'b0);
    check_bit("abort.zero3", zero3, 1'b0);
    repeat (5) @(negedge clk);
    check_bit("abort.idle_done", done, 1'b0);
    run("after_abort", SW'(3), 1'b0, F2, F2, 1'b0);

    // A start while busy must not disturb the latched k
    start_op(SW'(3), 1'b0);
    repeat (5) @(negedge clk);
    start_op(SW'(2), 1'b0);
    check_bit("ignored.busy", busy, 1'b1);
    wait_done("ignored", busy_prev);
    expect_pt("ignored", F2, F2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
